// File: rtl/prog_loader.sv
// prog_loader: byte-stream front end for the CPU.
//
// Parses framed commands from a valid/ready byte stream:
//   CMD_IM  len_hi len_lo {hi lo}*N  -> N 16-bit instruction words at IM[0..N-1]
//   CMD_DM  len_hi len_lo {b}*N      -> N data bytes at DM[0..N-1]
//   CMD_RUN                          -> status=11 until end_process rises, then done
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_data_i/in_valid_i/in_ready_o   byte stream handshake
//   end_process_i       CPU completion level
//   status_o            CPU mode: 00 idle, 01 instr load, 10 data load, 11 run
//   im_we_o/im_addr_o/im_data_o       instruction memory write port
//   dm_we_o/dm_addr_o/dm_data_o       data memory write port
//   busy_o              high whenever the parser is not idle
//   done_o              one-cycle pulse when a run completes
//   err_o               sticky error, cleared by the next valid command byte
module prog_loader #(
    parameter int unsigned IM_DEPTH = 256,
    parameter int unsigned DM_DEPTH = 256,
    parameter logic [7:0]  CMD_IM   = 8'hA1,
    parameter logic [7:0]  CMD_DM   = 8'hA2,
    parameter logic [7:0]  CMD_RUN  = 8'hA3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        end_process_i,
    output logic [1:0]  status_o,
    output logic        im_we_o,
    output logic [15:0] im_addr_o,
    output logic [15:0] im_data_o,
    output logic        dm_we_o,
    output logic [15:0] dm_addr_o,
    output logic [7:0]  dm_data_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StPayHi,
        StPayLo,
        StRun
    } state_e;

    // 17 bits so a 16-bit length of 65535 compares correctly against any depth.
    localparam logic [16:0] ImDepthW = 17'(IM_DEPTH);
    localparam logic [16:0] DmDepthW = 17'(DM_DEPTH);

    state_e      state_q, state_d;
    logic        target_q, target_d;   // 0: instruction memory, 1: data memory
    logic [15:0] len_q, len_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  hi_q, hi_d;
    logic        armed_q, armed_d;     // end_process has been seen low during this run
    logic [1:0]  status_q, status_d;
    logic        im_we_q, im_we_d;
    logic [15:0] im_addr_q, im_addr_d;
    logic [15:0] im_data_q, im_data_d;
    logic        dm_we_q, dm_we_d;
    logic [15:0] dm_addr_q, dm_addr_d;
    logic [7:0]  dm_data_q, dm_data_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        in_ready;
    logic        accept;
    logic [15:0] len_full;
    logic [16:0] depth;
    logic [15:0] cnt_inc;

    assign in_ready = (state_q != StRun);
    assign accept   = in_valid_i && in_ready;
    assign len_full = {len_q[15:8], in_data_i};
    assign depth    = target_q ? DmDepthW : ImDepthW;
    assign cnt_inc  = cnt_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        armed_d   = armed_q;
        im_we_d   = 1'b0;
        im_addr_d = im_addr_q;
        im_data_d = im_data_q;
        dm_we_d   = 1'b0;
        dm_addr_d = dm_addr_q;
        dm_data_d = dm_data_q;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (in_data_i == CMD_IM || in_data_i == CMD_DM) begin
                        target_d = (in_data_i == CMD_DM);
                        err_d    = 1'b0;
                        state_d  = StLenHi;
                    end else if (in_data_i == CMD_RUN) begin
                        err_d   = 1'b0;
                        // A completion flag already high at launch is stale.
                        armed_d = ~end_process_i;
                        state_d = StRun;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StLenHi: begin
                if (accept) begin
                    len_d   = {in_data_i, len_q[7:0]};
                    state_d = StLenLo;
                end
            end
            StLenLo: begin
                if (accept) begin
                    len_d = len_full;
                    if (len_full == 16'd0) begin
                        state_d = StIdle;
                    end else if ({1'b0, len_full} > depth) begin
                        err_d   = 1'b1;
                        state_d = StIdle;
                    end else begin
                        cnt_d   = 16'd0;
                        state_d = target_q ? StPayLo : StPayHi;
                    end
                end
            end
            StPayHi: begin
                if (accept) begin
                    hi_d    = in_data_i;
                    state_d = StPayLo;
                end
            end
            StPayLo: begin
                if (accept) begin
                    if (target_q) begin
                        dm_we_d   = 1'b1;
                        dm_addr_d = cnt_q;
                        dm_data_d = in_data_i;
                    end else begin
                        im_we_d   = 1'b1;
                        im_addr_d = cnt_q;
                        im_data_d = {hi_q, in_data_i};
                    end
                    cnt_d = cnt_inc;
                    if (cnt_inc == len_q) begin
                        state_d = StIdle;
                    end else begin
                        state_d = target_q ? StPayLo : StPayHi;
                    end
                end
            end
            StRun: begin
                armed_d = armed_q | ~end_process_i;
                if (armed_q && end_process_i) begin
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status follows the current state with one cycle of lag.
    always_comb begin
        status_d = 2'b00;
        case (state_q)
            StLenHi, StLenLo, StPayHi, StPayLo: status_d = target_q ? 2'b10 : 2'b01;
            StRun:                               status_d = 2'b11;
            default:                             status_d = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            target_q  <= 1'b0;
            len_q     <= '0;
            cnt_q     <= '0;
            hi_q      <= '0;
            armed_q   <= 1'b0;
            status_q  <= 2'b00;
            im_we_q   <= 1'b0;
            im_addr_q <= '0;
            im_data_q <= '0;
            dm_we_q   <= 1'b0;
            dm_addr_q <= '0;
            dm_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            armed_q   <= armed_d;
            status_q  <= status_d;
            im_we_q   <= im_we_d;
            im_addr_q <= im_addr_d;
            im_data_q <= im_data_d;
            dm_we_q   <= dm_we_d;
            dm_addr_q <= dm_addr_d;
            dm_data_q <= dm_data_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign in_ready_o = in_ready;
    assign status_o   = status_q;
    assign im_we_o    = im_we_q;
    assign im_addr_o  = im_addr_q;
    assign im_data_o  = im_data_q;
    assign dm_we_o    = dm_we_q;
    assign dm_addr_o  = dm_addr_q;
    assign dm_data_o  = dm_data_q;
    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: write strobes are checked against a
// scoreboard of expected (addr, data) pairs pushed as each payload is driven.
module tb_prog_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        end_process;
    logic [1:0]  status;
    logic        im_we;
    logic [15:0] im_addr;
    logic [15:0] im_data;
    logic        dm_we;
    logic [15:0] dm_addr;
    logic [7:0]  dm_data;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    logic [31:0] exp_im[$];
    logic [23:0] exp_dm[$];

    prog_loader dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_data_i     (in_data),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .end_process_i (end_process),
        .status_o      (status),
        .im_we_o       (im_we),
        .im_addr_o     (im_addr),
        .im_data_o     (im_data),
        .dm_we_o       (dm_we),
        .dm_addr_o     (dm_addr),
        .dm_data_o     (dm_data),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: every write strobe must match the next expected entry.
    always @(posedge clk) begin
        logic [31:0] ei;
        logic [23:0] ed;
        #1;
        if (rst_n) begin
            if (im_we && dm_we) begin
                errors++;
                $display("FAIL both_strobes: im_we=%b dm_we=%b, required at most one", im_we, dm_we);
            end
            if (im_we) begin
                checks++;
                if (exp_im.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_im_write: addr=%h data=%h, required no write",
                             im_addr, im_data);
                end else begin
                    ei = exp_im.pop_front();
                    if ({im_addr, im_data} !== ei) begin
                        errors++;
                        $display("FAIL im_write: got addr=%h data=%h, required addr=%h data=%h",
                                 im_addr, im_data, ei[31:16], ei[15:0]);
                    end
                end
            end
            if (dm_we) begin
                checks++;
                if (exp_dm.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_dm_write: addr=%h data=%h, required no write",
                             dm_addr, dm_data);
                end else begin
                    ed = exp_dm.pop_front();
                    if ({dm_addr, dm_data} !== ed) begin
                        errors++;
                        $display("FAIL dm_write: got addr=%h data=%h, required addr=%h data=%h",
                                 dm_addr, dm_data, ed[23:8], ed[7:0]);
                    end
                end
            end
            if (done) done_cnt++;
        end
    end

    // Offer one byte after a random idle gap; returns 1 ns after the transfer edge.
    task automatic send_byte(input logic [7:0] b, input int unsigned max_gap);
        int n;
        repeat ($urandom_range(0, max_gap)) @(negedge clk);
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            errors++;
            $display("FAIL send_timeout: in_ready=%b for byte %h, required 1", in_ready, b);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b1;
        in_data     = 8'hA1;
        end_process = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({status, im_we, dm_we, busy, done, err, in_ready} !== 8'b00_0_0_0_0_0_1) begin
            errors++;
            $display("FAIL reset_ctrl: status=%b im_we=%b dm_we=%b busy=%b done=%b err=%b rdy=%b, required 00 0 0 0 0 0 1",
                     status, im_we, dm_we, busy, done, err, in_ready);
        end
        checks++;
        if ({im_addr, im_data, dm_addr, dm_data} !== 56'd0) begin
            errors++;
            $display("FAIL reset_bus: got %h %h %h %h, required all zero",
                     im_addr, im_data, dm_addr, dm_data);
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({status, busy, in_ready} !== 4'b00_0_1) begin
            errors++;
            $display("FAIL post_reset_idle: status=%b busy=%b rdy=%b, required 00 0 1",
                     status, busy, in_ready);
        end
    endtask

    task automatic test_instr_load(input int unsigned gap);
        exp_im.push_back({16'd0, 16'h1234});
        exp_im.push_back({16'd1, 16'hABCD});
        send_byte(8'hA1, gap);
        send_byte(8'h00, gap);
        checks++;
        if (status !== 2'b01) begin
            errors++;
            $display("FAIL im_status_load: status=%b, required 01", status);
        end
        send_byte(8'h02, gap);
        send_byte(8'h12, gap);
        send_byte(8'h34, gap);
        send_byte(8'hAB, gap);
        send_byte(8'hCD, gap);
        checks++;
        if ({busy, im_we} !== 2'b01) begin
            errors++;
            $display("FAIL im_last_write: busy=%b im_we=%b, required busy=0 im_we=1", busy, im_we);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (status !== 2'b00 || exp_im.size() != 0) begin
            errors++;
            $display("FAIL im_load_end: status=%b pending=%0d, required 00 and 0",
                     status, exp_im.size());
        end
    endtask

    task automatic test_data_run();
        exp_dm.push_back({16'd0, 8'h05});
        exp_dm.push_back({16'd1, 8'h06});
        exp_dm.push_back({16'd2, 8'h07});
        send_byte(8'hA2, 0);
        send_byte(8'h00, 0);
        checks++;
        if (status !== 2'b10) begin
            errors++;
            $display("FAIL dm_status_load: status=%b, required 10", status);
        end
        send_byte(8'h03, 0);
        send_byte(8'h05, 0);
        send_byte(8'h06, 0);
        send_byte(8'h07, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_dm.size() != 0) begin
            errors++;
            $display("FAIL dm_load_end: pending=%0d, required 0", exp_dm.size());
        end
        send_byte(8'hA3, 0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL run_ready: in_ready=%b, required 0", in_ready);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (status !== 2'b11 || done_cnt != 0) begin
            errors++;
            $display("FAIL run_wait: status=%b dones=%0d, required 11 and 0", status, done_cnt);
        end
        end_process = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL run_done: done=%b busy=%b, required 1 0", done, busy);
        end
        @(negedge clk);
        end_process = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || status !== 2'b00 || done_cnt != 1) begin
            errors++;
            $display("FAIL run_end: done=%b status=%b dones=%0d, required 0 00 1",
                     done, status, done_cnt);
        end
    endtask

    task automatic test_errors();
        send_byte(8'h55, 0);
        checks++;
        if ({err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL bad_cmd: err=%b busy=%b, required 1 0", err, busy);
        end
        send_byte(8'hA1, 0);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear_cmd: err=%b, required 0", err);
        end
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        checks++;
        if ({err, busy} !== 2'b10) begin
            errors++;
            $display("FAIL too_long: err=%b busy=%b, required 1 0", err, busy);
        end
        send_byte(8'hA2, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        checks++;
        if ({err, busy} !== 2'b00) begin
            errors++;
            $display("FAIL zero_len: err=%b busy=%b, required 0 0", err, busy);
        end
    endtask

    task automatic test_stale_end();
        int d0;
        d0 = done_cnt;
        end_process = 1'b1;
        send_byte(8'hA3, 0);
        repeat (5) @(negedge clk);
        checks++;
        if (status !== 2'b11 || done_cnt != d0) begin
            errors++;
            $display("FAIL stale_end: status=%b dones=%0d, required 11 and %0d",
                     status, done_cnt, d0);
        end
        end_process = 1'b0;
        repeat (2) @(negedge clk);
        end_process = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL fresh_end: done=%b, required 1", done);
        end
        @(negedge clk);
        end_process = 1'b0;
    endtask

    task automatic test_back_to_back();
        send_byte(8'hA3, 0);
        @(negedge clk);
        in_data  = 8'hA2;
        in_valid = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || status !== 2'b11) begin
            errors++;
            $display("FAIL run_hold: in_ready=%b status=%b, required 0 11", in_ready, status);
        end
        end_process = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL hold_done: done=%b, required 1", done);
        end
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        end_process = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (status !== 2'b10) begin
            errors++;
            $display("FAIL held_cmd: status=%b, required 10", status);
        end
        exp_dm.push_back({16'd0, 8'h09});
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h09, 0);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_dm.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL held_load: pending=%0d busy=%b, required 0 0", exp_dm.size(), busy);
        end
    endtask

    task automatic test_mid_reset();
        exp_im.push_back({16'd0, 16'h1234});
        send_byte(8'hA1, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h78;
        #1;
        checks++;
        if ({status, im_we, busy, err, in_ready} !== 6'b00_0_0_0_1 ||
            {im_addr, im_data} !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset: status=%b im_we=%b busy=%b err=%b rdy=%b addr=%h data=%h, required idle zeros",
                     status, im_we, busy, err, in_ready, im_addr, im_data);
        end
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        exp_im.push_back({16'd0, 16'hAABB});
        send_byte(8'hA1, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_im.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_load: pending=%0d busy=%b, required 0 0",
                     exp_im.size(), busy);
        end
    endtask

    initial begin
        test_reset();
        test_instr_load(0);
        test_data_run();
        test_errors();
        test_instr_load(3);
        test_stale_end();
        test_back_to_back();
        test_mid_reset();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_im.size() != 0 || exp_dm.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: im=%0d dm=%0d pending, required 0 0",
                     exp_im.size(), exp_dm.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
